// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment codes and defaults.
// Segment lines are active-low (0 lights a segment); bit 0 is segment a through bit 6 segment g.
package ssd_pkg;

   localparam int SSD_NDIG = 4;

   localparam logic [6:0] SSD_0     = 7'h40;
   localparam logic [6:0] SSD_1     = 7'h79;
   localparam logic [6:0] SSD_2     = 7'h24;
   localparam logic [6:0] SSD_3     = 7'h30;
   localparam logic [6:0] SSD_4     = 7'h19;
   localparam logic [6:0] SSD_5     = 7'h12;
   localparam logic [6:0] SSD_6     = 7'h02;
   localparam logic [6:0] SSD_7     = 7'h78;
   localparam logic [6:0] SSD_8     = 7'h00;
   localparam logic [6:0] SSD_9     = 7'h10;
   localparam logic [6:0] SSD_A     = 7'h08;
   localparam logic [6:0] SSD_B     = 7'h03;
   localparam logic [6:0] SSD_C     = 7'h46;
   localparam logic [6:0] SSD_D     = 7'h21;
   localparam logic [6:0] SSD_E     = 7'h06;
   localparam logic [6:0] SSD_F     = 7'h0E;
   localparam logic [6:0] SSD_BLANK = 7'h7F;

endpackage

// File: rtl/ssd2hex.sv
// Combinational segment-pattern to nibble decoder; flags legal codes and the all-off blank.
module ssd2hex
   import ssd_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       hit,
   output logic       blank
);

   always_comb begin
      nibble = 4'h0;
      hit    = 1'b1;
      blank  = 1'b0;
      case (seg_n)
         SSD_0:     nibble = 4'h0;
         SSD_1:     nibble = 4'h1;
         SSD_2:     nibble = 4'h2;
         SSD_3:     nibble = 4'h3;
         SSD_4:     nibble = 4'h4;
         SSD_5:     nibble = 4'h5;
         SSD_6:     nibble = 4'h6;
         SSD_7:     nibble = 4'h7;
         SSD_8:     nibble = 4'h8;
         SSD_9:     nibble = 4'h9;
         SSD_A:     nibble = 4'hA;
         SSD_B:     nibble = 4'hB;
         SSD_C:     nibble = 4'hC;
         SSD_D:     nibble = 4'hD;
         SSD_E:     nibble = 4'hE;
         SSD_F:     nibble = 4'hF;
         SSD_BLANK: begin
            hit   = 1'b0;
            blank = 1'b1;
         end
         default:   hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Reader for a multiplexed seven-segment bus: synchronizes, filters for stability,
// decodes each digit and reports per-digit values, frame completion and code errors.
module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int NDIG          = SSD_NDIG,
   parameter int STABLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [6:0]        seg_n,
   input  logic [NDIG-1:0]   dig_sel,
   output logic [4*NDIG-1:0] hex_out,
   output logic [NDIG-1:0]   dig_valid,
   output logic              frame_valid,
   output logic              code_err
);

   localparam int            CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic [6:0]        seg_p0, seg_p1;
   logic [NDIG-1:0]   dig_p0, dig_p1;
   logic [CW-1:0]     cnt_p2;
   logic              acc_p2;
   logic [NDIG-1:0]   seen;

   logic [3:0]        nib;
   logic              hit, blank;
   logic              changed, accept, sel_one, sel_multi;
   logic [4*NDIG-1:0] hex_nxt;
   logic [NDIG-1:0]   dv_nxt, seen_nxt;
   logic              err_nxt;

   ssd2hex u_dec (
      .seg_n  (seg_p1),
      .nibble (nib),
      .hit    (hit),
      .blank  (blank)
   );

   // Stage p2: stability decision and slot update from sample S (seg_p1/dig_p1)
   always_comb begin
      changed   = (seg_p0 != seg_p1) || (dig_p0 != dig_p1);
      accept    = (cnt_p2 == LAST) && !acc_p2;
      sel_one   = $onehot(dig_p1);
      sel_multi = (dig_p1 != '0) && !sel_one;

      hex_nxt  = hex_out;
      dv_nxt   = dig_valid;
      seen_nxt = (seen == '1) ? '0 : seen;
      err_nxt  = code_err;

      if (accept) begin
         if (sel_multi) begin
            err_nxt = 1'b1;
         end else if (sel_one) begin
            if (!hit && !blank) err_nxt = 1'b1;
            for (int i = 0; i < NDIG; i++) begin
               if (dig_p1[i]) begin
                  seen_nxt[i] = 1'b1;
                  if (hit) begin
                     hex_nxt[4*i +: 4] = nib;
                     dv_nxt[i]         = 1'b1;
                  end else if (blank) begin
                     dv_nxt[i] = 1'b0;
                  end
               end
            end
         end
      end

      // A clear discards the same-cycle accept entirely
      if (clr) begin
         hex_nxt  = hex_out;
         dv_nxt   = '0;
         seen_nxt = '0;
         err_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_p0      <= SSD_BLANK;
         seg_p1      <= SSD_BLANK;
         dig_p0      <= '0;
         dig_p1      <= '0;
         cnt_p2      <= '0;
         acc_p2      <= 1'b0;
         seen        <= '0;
         hex_out     <= '0;
         dig_valid   <= '0;
         frame_valid <= 1'b0;
         code_err    <= 1'b0;
      end else begin
         // Stages p0/p1: two-flop synchronizer
         seg_p0 <= seg_n;
         seg_p1 <= seg_p0;
         dig_p0 <= dig_sel;
         dig_p1 <= dig_p0;

         // The flag keeps a saturated run from being accepted twice
         if (changed) begin
            cnt_p2 <= '0;
            acc_p2 <= 1'b0;
         end else begin
            if (cnt_p2 != LAST) cnt_p2 <= cnt_p2 + 1'b1;
            if (accept) acc_p2 <= 1'b1;
         end

         frame_valid <= (seen == '1);
         seen        <= seen_nxt;
         hex_out     <= hex_nxt;
         dig_valid   <= dv_nxt;
         code_err    <= err_nxt;
      end
   end

endmodule
